// File: rtl/vec_reduce_seq.sv
// rtl/vec_reduce_seq.sv - sequential floating-point vector sum engine
//
// Modules in this file:
//   float_add      : combinational IEEE-754 style adder, round-to-nearest-even
//   vec_sum_reduce : one pairwise pass, N lanes -> ceil(N/2) lanes, odd lane passes through
//   vec_reduce_seq : top; loads a vector and re-applies one vec_sum_reduce until one lane remains
//
// Top ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   input vector handshake; in_data is VEC_SIZE elements of W bits
//   in_last             last chunk of a dot product (accumulator build only)
//   out_valid/out_ready result handshake; out_data is the W-bit scalar sum
//   busy                engine is not idle
//
// Build option: define VEC_REDUCE_ACC_EN to accumulate chunk sums across vectors
// until a chunk flagged with in_last, producing one output per dot product.

module float_add #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23
) (
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] a_i,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] b_i,
    output logic [EXP_WIDTH+FRAC_WIDTH:0] y_o
);
    localparam int E    = EXP_WIDTH;
    localparam int F    = FRAC_WIDTH;
    localparam int W    = 1 + E + F;
    localparam int M    = F + 4;          // hidden bit, fraction, guard, round, sticky
    localparam int EMAX = (1 << E) - 1;

    logic         sa, sb;
    logic [E-1:0] xa, xb;
    logic [F-1:0] fa, fb;

    assign {sa, xa, fa} = a_i;
    assign {sb, xb, fb} = b_i;

    logic         s_big, s_sml, sticky, inc, found;
    logic         nan_a, nan_b, inf_a, inf_b;
    logic [E-1:0] x_big, x_sml, x_out;
    logic [F-1:0] f_big, f_sml, f_out;
    logic [M-1:0] m_big, m_sml, m_shf, mask, n;
    logic [M:0]   s;
    logic [F+1:0] mant;
    int           e_big, e_sml, diff, e_res, lz, sh;

    always_comb begin
        s_big = sa; s_sml = sb; x_big = xa; x_sml = xb; f_big = fa; f_sml = fb;
        sticky = 1'b0; inc = 1'b0; found = 1'b0;
        x_out = '0; f_out = '0; m_shf = '0; mask = '0; n = '0; s = '0; mant = '0;
        lz = M; sh = 0;
        y_o = '0;

        // Order operands by magnitude so the subtraction never goes negative.
        if (a_i[W-2:0] < b_i[W-2:0]) begin
            s_big = sb; s_sml = sa; x_big = xb; x_sml = xa; f_big = fb; f_sml = fa;
        end

        // Subnormals share the exponent of the smallest normal and have no hidden bit.
        e_big = (x_big == '0) ? 1 : int'(x_big);
        e_sml = (x_sml == '0) ? 1 : int'(x_sml);
        m_big = {(x_big != '0), f_big, 3'b000};
        m_sml = {(x_sml != '0), f_sml, 3'b000};
        diff  = e_big - e_sml;

        if (diff >= M) begin
            sticky = |m_sml;
        end else begin
            mask   = ~({M{1'b1}} << diff);
            sticky = |(m_sml & mask);
            m_shf  = m_sml >> diff;
        end
        m_shf[0] = m_shf[0] | sticky;

        if (s_big == s_sml) s = {1'b0, m_big} + {1'b0, m_shf};
        else                s = {1'b0, m_big} - {1'b0, m_shf};

        for (int i = M - 1; i >= 0; i--) begin
            if (!found && s[i]) begin
                lz    = M - 1 - i;
                found = 1'b1;
            end
        end

        e_res = e_big;
        if (s[M]) begin
            n     = s[M:1];
            n[0]  = n[0] | s[0];
            e_res = e_big + 1;
        end else begin
            // Never normalise below the minimum exponent; the result goes subnormal instead.
            sh    = (lz < e_big - 1) ? lz : e_big - 1;
            n     = s[M-1:0] << sh;
            e_res = e_big - sh;
        end

        inc  = n[2] & (n[1] | n[0] | n[3]);
        mant = {1'b0, n[M-1:3]} + {{(F+1){1'b0}}, inc};

        if (mant[F+1]) begin
            e_res = e_res + 1;
            f_out = '0;
            x_out = E'(e_res);
        end else begin
            f_out = mant[F-1:0];
            x_out = mant[F] ? E'(e_res) : '0;
        end

        if (s == '0)           y_o = {sa & sb, {(W-1){1'b0}}};
        else if (e_res >= EMAX) y_o = {s_big, {E{1'b1}}, {F{1'b0}}};
        else                   y_o = {s_big, x_out, f_out};

        nan_a = (xa == {E{1'b1}}) && (fa != '0);
        nan_b = (xb == {E{1'b1}}) && (fb != '0);
        inf_a = (xa == {E{1'b1}}) && (fa == '0);
        inf_b = (xb == {E{1'b1}}) && (fb == '0);
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb)))
            y_o = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
        else if (inf_a)
            y_o = a_i;
        else if (inf_b)
            y_o = b_i;
    end
endmodule

module vec_sum_reduce #(
    parameter int N          = 4,
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23
) (
    input  logic [N*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]           vec_i,
    output logic [((N+1)/2)*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]   vec_o
);
    localparam int W  = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int NO = (N + 1) / 2;

    for (genvar i = 0; i < N / 2; i++) begin : g_pair
        float_add #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_add (
            .a_i (vec_i[(2*i)*W +: W]),
            .b_i (vec_i[(2*i+1)*W +: W]),
            .y_o (vec_o[i*W +: W])
        );
    end

    if (N % 2 == 1) begin : g_odd
        assign vec_o[(NO-1)*W +: W] = vec_i[(N-1)*W +: W];
    end
endmodule

module vec_reduce_seq #(
    parameter int VEC_SIZE   = 4,
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [VEC_SIZE*(1+EXP_WIDTH+FRAC_WIDTH)-1:0] in_data,
    input  logic                                         in_last,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]                out_data,
    output logic                                         busy
);
    localparam int W  = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int NO = (VEC_SIZE + 1) / 2;
    localparam int P  = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 0;
    localparam int CW = (P > 0) ? $clog2(P + 1) : 1;
    localparam logic [CW-1:0] LAST_PASS = CW'((P > 0) ? P - 1 : 0);

`ifdef VEC_REDUCE_ACC_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REDUCE = 2'd1, S_DONE = 2'd2, S_ACC = 2'd3} state_t;
    localparam state_t S_AFTER = S_ACC;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REDUCE = 2'd1, S_DONE = 2'd2} state_t;
    localparam state_t S_AFTER = S_DONE;
`endif

    state_t                    state_q, state_d;
    logic [VEC_SIZE*W-1:0]     vreg_q, vreg_d, red_wide;
    logic [NO*W-1:0]           red;
    logic [CW-1:0]             cnt_q, cnt_d;

    // Same full-width stage every pass: lanes beyond the live ones hold +0, so the
    // result matches a pairwise tree over the original vector.
    vec_sum_reduce #(.N(VEC_SIZE), .EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_red (
        .vec_i (vreg_q),
        .vec_o (red)
    );

    always_comb begin
        red_wide          = '0;
        red_wide[NO*W-1:0] = red;
    end

`ifdef VEC_REDUCE_ACC_EN
    logic [W-1:0] acc_q, acc_d, acc_sum;
    logic         last_q, last_d;

    float_add #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_acc (
        .a_i (acc_q),
        .b_i (vreg_q[W-1:0]),
        .y_o (acc_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            last_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            last_q <= last_d;
        end
    end

    assign out_data = acc_q;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign out_data       = vreg_q[W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        vreg_d  = vreg_q;
        cnt_d   = cnt_q;
`ifdef VEC_REDUCE_ACC_EN
        acc_d   = acc_q;
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    vreg_d  = in_data;
                    cnt_d   = '0;
`ifdef VEC_REDUCE_ACC_EN
                    last_d  = in_last;
`endif
                    state_d = (P == 0) ? S_AFTER : S_REDUCE;
                end
            end
            S_REDUCE: begin
                vreg_d = red_wide;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_PASS) state_d = S_AFTER;
            end
`ifdef VEC_REDUCE_ACC_EN
            S_ACC: begin
                acc_d   = acc_sum;
                state_d = last_q ? S_DONE : S_IDLE;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
`ifdef VEC_REDUCE_ACC_EN
                    acc_d   = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vreg_q  <= vreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pure state decodes: no combinational path from the handshake inputs.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_vec_reduce_seq.sv
// tb/tb_vec_reduce_seq.sv - directed self-checking bench for vec_reduce_seq
module tb_vec_reduce_seq;
`ifdef VEC_REDUCE_ACC_EN
    localparam int EX = 1;
`else
    localparam int EX = 0;
`endif
    localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000;
    localparam logic [31:0] F4 = 32'h40800000, F5 = 32'h40A00000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         v4_in_valid, v4_in_ready, v4_in_last, v4_out_valid, v4_out_ready, v4_busy;
    logic [127:0] v4_in_data;
    logic [31:0]  v4_out_data;
    logic         v5_in_valid, v5_in_ready, v5_in_last, v5_out_valid, v5_out_ready, v5_busy;
    logic [159:0] v5_in_data;
    logic [31:0]  v5_out_data;
    logic         v1_in_valid, v1_in_ready, v1_in_last, v1_out_valid, v1_out_ready, v1_busy;
    logic [31:0]  v1_in_data;
    logic [31:0]  v1_out_data;

    vec_reduce_seq #(.VEC_SIZE(4), .EXP_WIDTH(8), .FRAC_WIDTH(23)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
        .in_data(v4_in_data), .in_last(v4_in_last), .out_valid(v4_out_valid),
        .out_ready(v4_out_ready), .out_data(v4_out_data), .busy(v4_busy));
    vec_reduce_seq #(.VEC_SIZE(5), .EXP_WIDTH(8), .FRAC_WIDTH(23)) dut5 (
        .clk(clk), .rst(rst), .in_valid(v5_in_valid), .in_ready(v5_in_ready),
        .in_data(v5_in_data), .in_last(v5_in_last), .out_valid(v5_out_valid),
        .out_ready(v5_out_ready), .out_data(v5_out_data), .busy(v5_busy));
    vec_reduce_seq #(.VEC_SIZE(1), .EXP_WIDTH(8), .FRAC_WIDTH(23)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .in_data(v1_in_data), .in_last(v1_in_last), .out_valid(v1_out_valid),
        .out_ready(v1_out_ready), .out_data(v1_out_data), .busy(v1_busy));

    int          sel;
    logic        cur_valid;
    logic [31:0] cur_data;
    always_comb begin
        cur_valid = v4_out_valid;
        cur_data  = v4_out_data;
        if (sel == 5) begin cur_valid = v5_out_valid; cur_data = v5_out_data; end
        if (sel == 1) begin cur_valid = v1_out_valid; cur_data = v1_out_data; end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Takes the handshake edge, then counts edges until the selected out_valid is seen.
    task automatic wait_valid(output int n);
        @(posedge clk); #1;
        v4_in_valid = 1'b0; v5_in_valid = 1'b0; v1_in_valid = 1'b0;
        n = 1;
        while (!cur_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    int   n;
    logic seen;

    initial begin
        rst = 1'b1; sel = 4;
        v4_in_valid = 0; v4_in_last = 1; v4_out_ready = 0; v4_in_data = '0;
        v5_in_valid = 0; v5_in_last = 1; v5_out_ready = 1; v5_in_data = '0;
        v1_in_valid = 0; v1_in_last = 1; v1_out_ready = 1; v1_in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(v4_in_ready), 32'd1);
        check("rst_out_valid", 32'(v4_out_valid), 32'd0);
        check("rst_busy", 32'(v4_busy), 32'd0);
        check("rst_out_data", v4_out_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // {4,3,2,1} with the consumer stalled
        v4_in_data = {F4, F3, F2, F1}; v4_in_valid = 1'b1;
        wait_valid(n);
        check("v4_latency", 32'(n), 32'(3 + EX));
        check("v4_sum", v4_out_data, 32'h41200000);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin v4_in_data = {F1, F1, F1, F1}; v4_in_valid = 1'b1; end
            @(posedge clk); #1;
            v4_in_valid = 1'b0;
            check("bp_hold_data", v4_out_data, 32'h41200000);
            check("bp_in_ready", 32'(v4_in_ready), 32'd0);
            check("bp_out_valid", 32'(v4_out_valid), 32'd1);
        end
        v4_out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(v4_in_ready), 32'd1);
        check("bp_release_out_valid", 32'(v4_out_valid), 32'd0);
        @(posedge clk); #1;
        check("bp_pulse_ignored", 32'(v4_busy), 32'd0);

        // 2.5 + -1.5 and 0.25 + -0.75 -> 1.0 + -0.5 = 0.5
        v4_in_data = {32'hBF400000, 32'h3E800000, 32'hBFC00000, 32'h40200000}; v4_in_valid = 1'b1;
        wait_valid(n);
        check("mixed_latency", 32'(n), 32'(3 + EX));
        check("mixed_sum", v4_out_data, 32'h3F000000);
        @(posedge clk); #1;

        // Five elements: odd passthrough over three passes
        sel = 5;
        v5_in_data = {F5, F4, F3, F2, F1}; v5_in_valid = 1'b1;
        wait_valid(n);
        check("v5_latency", 32'(n), 32'(4 + EX));
        check("v5_sum", v5_out_data, 32'h41700000);
        @(posedge clk); #1;

        // Single element
        sel = 1;
        v1_in_data = 32'hC0000000; v1_in_valid = 1'b1;
        wait_valid(n);
        check("v1_latency", 32'(n), 32'(1 + EX));
        check("v1_value", v1_out_data, 32'hC0000000);
        @(posedge clk); #1;

        // Reset during the second REDUCE cycle
        sel = 4;
        v4_in_data = {F4, F3, F2, F1}; v4_in_valid = 1'b1;
        @(posedge clk); #1;
        v4_in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_before", 32'(v4_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(v4_out_valid), 32'd0);
        check("abort_in_ready", 32'(v4_in_ready), 32'd1);
        check("abort_busy", 32'(v4_busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        v4_in_data = {F1, F1, F1, F1}; v4_in_valid = 1'b1;
        wait_valid(n);
        check("after_abort_latency", 32'(n), 32'(3 + EX));
        check("after_abort_sum", v4_out_data, F4);
        @(posedge clk); #1;

`ifdef VEC_REDUCE_ACC_EN
        // Two chunks accumulate into one result; acc clears after it is taken.
        v4_in_data = {F1, F1, F1, F1}; v4_in_last = 1'b0; v4_in_valid = 1'b1;
        @(posedge clk); #1;
        v4_in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !v4_in_ready; c++) begin
            seen = seen | v4_out_valid;
            @(posedge clk); #1;
        end
        check("acc_no_partial_output", 32'(seen), 32'd0);
        v4_in_data = {F2, F2, F2, F2}; v4_in_last = 1'b1; v4_in_valid = 1'b1;
        wait_valid(n);
        check("acc_latency", 32'(n), 32'd4);
        check("acc_sum", v4_out_data, 32'h41400000);
        @(posedge clk); #1;
        v4_in_data = {F1, F1, F1, F1}; v4_in_valid = 1'b1;
        wait_valid(n);
        check("acc_cleared_sum", v4_out_data, F4);
        @(posedge clk); #1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
